// File: rtl/sprite_pkg.sv
// ---------------------------------------------------------------------------
// sprite_pkg
//   Shared constants for the sprite pixel path: default pixel width, the
//   4:4:4 colour constants used by the sprite ROMs and the VGA colour mux,
//   the default transparency colour key and a clog2 helper that never
//   returns a zero-width result.
// ---------------------------------------------------------------------------
package sprite_pkg;

    localparam int COLOR_W = 12;

    localparam logic [COLOR_W-1:0] C_WHITE = 12'hFFF;
    localparam logic [COLOR_W-1:0] C_BLACK = 12'h000;
    localparam logic [COLOR_W-1:0] C_GREY  = 12'h777;

    // White is the background key used by the sprite artwork.
    localparam logic [COLOR_W-1:0] TRANSPARENT_DEFAULT = C_WHITE;

    // Index width for n entries, at least one bit so that single-entry
    // dimensions (e.g. NUM_FRAMES=1) still produce a legal port.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sprite_frame_bram.sv
// ---------------------------------------------------------------------------
// sprite_frame_bram
//   Single-port, registered-output ROM holding every animation frame of one
//   sprite. The array itself has no reset so it maps onto a block RAM.
// Ports
//   clk      in   1    system clock
//   rd_en    in   1    read strobe; rd_data holds its value when low
//   addr     in   AW   word address
//   rd_data  out  DW   registered read data
// ---------------------------------------------------------------------------
module sprite_frame_bram #(
    parameter int    DEPTH     = 2048,
    parameter int    AW        = 11,
    parameter int    DW        = 12,
    parameter string INIT_FILE = ""
) (
    input  logic          clk,
    input  logic          rd_en,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] rd_data
);

    (* rom_style = "block" *) logic [DW-1:0] mem [0:DEPTH-1];

    logic [DW-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_q <= mem[addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sprite_anim_rom.sv
// ---------------------------------------------------------------------------
// sprite_anim_rom
//   Multi-frame sprite colour ROM with animation frame counter, horizontal
//   flip, transparency flag and a fixed two-cycle read pipeline.
// Ports
//   clk           in   1        system clock
//   reset         in   1        synchronous, active-high
//   rd_en         in   1        pixel request valid this cycle
//   row           in   RW       sprite-local row
//   col           in   CW       sprite-local column
//   flip_h        in   1        mirror horizontally
//   anim_en       in   1        frame counter advances on frame_tick
//   frame_tick    in   1        one pulse per video frame
//   frame_restart in   1        jump to frame 0 and clear the tick count
//   color_data    out  COLOR_W  pixel colour (2 cycles after the request)
//   color_valid   out  1        color_data belongs to a request 2 cycles ago
//   opaque        out  1        in range and colour differs from TRANSPARENT
//   frame_idx     out  FW       current animation frame
// ---------------------------------------------------------------------------
module sprite_anim_rom #(
    parameter int                  SPR_W       = 32,
    parameter int                  SPR_H       = 16,
    parameter int                  COLOR_W     = sprite_pkg::COLOR_W,
    parameter int                  NUM_FRAMES  = 4,
    parameter int                  FRAME_TICKS = 8,
    parameter logic [COLOR_W-1:0]  TRANSPARENT = sprite_pkg::TRANSPARENT_DEFAULT,
    parameter string               INIT_FILE   = "",
    localparam int                 CW          = sprite_pkg::clog2_min1(SPR_W),
    localparam int                 RW          = sprite_pkg::clog2_min1(SPR_H),
    localparam int                 FW          = sprite_pkg::clog2_min1(NUM_FRAMES)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rd_en,
    input  logic [RW-1:0]      row,
    input  logic [CW-1:0]      col,
    input  logic               flip_h,
    input  logic               anim_en,
    input  logic               frame_tick,
    input  logic               frame_restart,
    output logic [COLOR_W-1:0] color_data,
    output logic               color_valid,
    output logic               opaque,
    output logic [FW-1:0]      frame_idx
);
    import sprite_pkg::*;

    localparam int FRAME_SIZE = SPR_H * SPR_W;
    localparam int DEPTH      = NUM_FRAMES * FRAME_SIZE;
    localparam int AW         = clog2_min1(DEPTH);
    localparam int TW         = $clog2(FRAME_TICKS) + 1;

    logic [FW-1:0]      frame_q, frame_d;
    logic [TW-1:0]      tick_q, tick_d;
    logic               s1_valid_q, s1_valid_d;
    logic               s1_in_range_q, s1_in_range_d;
    logic [AW-1:0]      s1_addr_q, s1_addr_d;
    logic               s2_valid_q, s2_valid_d;
    logic               s2_in_range_q, s2_in_range_d;
    logic [CW-1:0]      col_eff;
    logic [COLOR_W-1:0] bram_data;

    // Frame counter: restart beats tick; anim_en=0 freezes both counters.
    always_comb begin
        frame_d = frame_q;
        tick_d  = tick_q;
        if (frame_restart) begin
            frame_d = '0;
            tick_d  = '0;
        end else if (anim_en && frame_tick) begin
            if (tick_q == TW'(FRAME_TICKS - 1)) begin
                tick_d  = '0;
                frame_d = (frame_q == FW'(NUM_FRAMES - 1)) ? '0 : frame_q + FW'(1);
            end else begin
                tick_d = tick_q + TW'(1);
            end
        end
    end

    // Stage 1: address formation. The frame index is the one current in the
    // request cycle, so a frame step on the same edge does not leak in.
    // Out-of-range coordinates park the address at 0 so the ROM is never
    // indexed past its end when sizes are not powers of two.
    always_comb begin
        col_eff       = flip_h ? (CW'(SPR_W - 1) - col) : col;
        s1_valid_d    = rd_en;
        s1_in_range_d = (32'(row) < SPR_H) && (32'(col) < SPR_W);
        s1_addr_d     = '0;
        if (s1_in_range_d) begin
            s1_addr_d = AW'(frame_q) * AW'(FRAME_SIZE)
                      + AW'(row) * AW'(SPR_W)
                      + AW'(col_eff);
        end
    end

    // Stage 2: the range flag only follows real requests so that colour and
    // opaque hold their last values while color_valid is low.
    always_comb begin
        s2_valid_d    = s1_valid_q;
        s2_in_range_d = s1_valid_q ? s1_in_range_q : s2_in_range_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_q       <= '0;
            tick_q        <= '0;
            s1_valid_q    <= 1'b0;
            s1_in_range_q <= 1'b0;
            s1_addr_q     <= '0;
            s2_valid_q    <= 1'b0;
            s2_in_range_q <= 1'b0;
        end else begin
            frame_q       <= frame_d;
            tick_q        <= tick_d;
            s1_valid_q    <= s1_valid_d;
            s1_in_range_q <= s1_in_range_d;
            s1_addr_q     <= s1_addr_d;
            s2_valid_q    <= s2_valid_d;
            s2_in_range_q <= s2_in_range_d;
        end
    end

    sprite_frame_bram #(
        .DEPTH     (DEPTH),
        .AW        (AW),
        .DW        (COLOR_W),
        .INIT_FILE (INIT_FILE)
    ) u_bram (
        .clk     (clk),
        .rd_en   (s1_valid_q),
        .addr    (s1_addr_q),
        .rd_data (bram_data)
    );

    // s2_in_range_q resets low, which forces the TRANSPARENT reset colour
    // without needing a reset on the memory output register.
    assign color_valid = s2_valid_q;
    assign color_data  = s2_in_range_q ? bram_data : TRANSPARENT;
    assign opaque      = s2_in_range_q && (bram_data != TRANSPARENT);
    assign frame_idx   = frame_q;

endmodule

// File: tb/tb_sprite_anim_rom.sv
// ---------------------------------------------------------------------------
// tb_sprite_anim_rom
//   Directed bench for sprite_anim_rom with default parameters
//   (32x16 sprite, 4 frames, 8 ticks per step, key 12'hFFF). The ROM image
//   is a known pattern written into the memory array at time 0.
// ---------------------------------------------------------------------------
module tb_sprite_anim_rom;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd_en = 1'b0;
    logic [3:0]  row = '0;
    logic [4:0]  col = '0;
    logic        flip_h = 1'b0;
    logic        anim_en = 1'b0;
    logic        frame_tick = 1'b0;
    logic        frame_restart = 1'b0;
    logic [11:0] color_data;
    logic        color_valid;
    logic        opaque;
    logic [1:0]  frame_idx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sprite_anim_rom dut (
        .clk           (clk),
        .reset         (reset),
        .rd_en         (rd_en),
        .row           (row),
        .col           (col),
        .flip_h        (flip_h),
        .anim_en       (anim_en),
        .frame_tick    (frame_tick),
        .frame_restart (frame_restart),
        .color_data    (color_data),
        .color_valid   (color_valid),
        .opaque        (opaque),
        .frame_idx     (frame_idx)
    );

    // Golden image: frame0 row2 col9 is grey, every 7th word is the
    // transparent key, everything else a scrambled address pattern.
    function automatic logic [11:0] gold(input int a);
        if (a == 73)         return 12'h777;
        else if (a % 7 == 0) return 12'hFFF;
        else                 return 12'((a * 37 + 5) % 4096);
    endfunction

    function automatic int pix_addr(input int f, input int r, input int c, input bit fl);
        return f * 512 + r * 32 + (fl ? 31 - c : c);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_pulses(input int n);
        repeat (n) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            step();
        end
    endtask

    // Single isolated request; valid must appear exactly two edges later.
    task automatic read_px(input string tag, input int f, input int r, input int c, input bit fl);
        logic [11:0] e;
        e      = gold(pix_addr(f, r, c, fl));
        rd_en  = 1'b1;
        row    = 4'(r);
        col    = 5'(c);
        flip_h = fl;
        step();
        rd_en = 1'b0;
        check({tag, "_valid_n1"}, 32'(color_valid), 32'd0);
        step();
        check({tag, "_valid_n2"}, 32'(color_valid), 32'd1);
        check({tag, "_data"}, 32'(color_data), 32'(e));
        check({tag, "_opaque"}, 32'(opaque), (e != 12'hFFF) ? 32'd1 : 32'd0);
        step();
        check({tag, "_valid_n3"}, 32'(color_valid), 32'd0);
    endtask

    initial begin
        int          exp_q[$];
        int          n_valid;
        int          r;
        int          c2;
        bit          fl;
        logic [11:0] e;

        for (int i = 0; i < 2048; i++) begin
            dut.u_bram.mem[i] = gold(i);
        end

        // Reset state
        reset = 1'b1;
        repeat (3) step();
        check("rst_frame", 32'(frame_idx), 32'd0);
        check("rst_valid", 32'(color_valid), 32'd0);
        check("rst_data", 32'(color_data), 32'hFFF);
        check("rst_opaque", 32'(opaque), 32'd0);

        // T1: requests in flight when reset hits are dropped
        reset  = 1'b0;
        rd_en  = 1'b1;
        row    = 4'd2;
        col    = 5'd9;
        step();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("t1_valid_rst%0d", k), 32'(color_valid), 32'd0);
        end
        rd_en = 1'b0;
        step();
        reset = 1'b0;
        step();
        check("t1_valid_after0", 32'(color_valid), 32'd0);
        step();
        check("t1_valid_after1", 32'(color_valid), 32'd0);
        check("t1_frame", 32'(frame_idx), 32'd0);
        check("t1_data", 32'(color_data), 32'hFFF);

        // T2 / T3: latency, flip and transparency
        read_px("t2_r2c9", 0, 2, 9, 1'b0);
        read_px("t3_flip_c22", 0, 2, 22, 1'b1);
        read_px("t3_noflip_c22", 0, 2, 22, 1'b0);
        read_px("t3_transp_r0c0", 0, 0, 0, 1'b0);
        read_px("t3_flip_r15c0", 0, 15, 0, 1'b1);
        read_px("t3_r7c5", 0, 7, 5, 1'b0);

        // T4: animation stepping, wrap and freeze
        anim_en = 1'b1;
        tick_pulses(7);
        check("t4_7ticks", 32'(frame_idx), 32'd0);
        tick_pulses(1);
        check("t4_8ticks", 32'(frame_idx), 32'd1);
        tick_pulses(8);
        check("t4_16ticks", 32'(frame_idx), 32'd2);
        tick_pulses(8);
        check("t4_24ticks", 32'(frame_idx), 32'd3);
        tick_pulses(8);
        check("t4_32ticks_wrap", 32'(frame_idx), 32'd0);
        tick_pulses(4);
        anim_en = 1'b0;
        tick_pulses(20);
        check("t4_frozen", 32'(frame_idx), 32'd0);
        anim_en = 1'b1;
        tick_pulses(3);
        check("t4_resume3", 32'(frame_idx), 32'd0);
        tick_pulses(1);
        check("t4_resume4", 32'(frame_idx), 32'd1);
        read_px("t4_f1_r2c9", 1, 2, 9, 1'b0);
        tick_pulses(8);
        check("t4_to2", 32'(frame_idx), 32'd2);

        // T5: restart wins over a simultaneous tick and clears the tick count
        tick_pulses(3);
        frame_restart = 1'b1;
        frame_tick    = 1'b1;
        step();
        frame_restart = 1'b0;
        frame_tick    = 1'b0;
        step();
        check("t5_restart", 32'(frame_idx), 32'd0);
        tick_pulses(7);
        check("t5_7ticks", 32'(frame_idx), 32'd0);
        tick_pulses(1);
        check("t5_8ticks", 32'(frame_idx), 32'd1);

        // T6a: request and frame step on the same cycle -> old frame's data
        tick_pulses(7);
        rd_en      = 1'b1;
        row        = 4'd2;
        col        = 5'd9;
        flip_h     = 1'b0;
        frame_tick = 1'b1;
        step();
        rd_en      = 1'b0;
        frame_tick = 1'b0;
        check("t6_frame_stepped", 32'(frame_idx), 32'd2);
        step();
        check("t6_sample_valid", 32'(color_valid), 32'd1);
        check("t6_sample_data", 32'(color_data), 32'(gold(pix_addr(1, 2, 9, 1'b0))));
        step();
        anim_en = 1'b0;

        // T6b: 512 back-to-back requests from frame 2, flip toggling every 64
        n_valid = 0;
        for (int c = 0; c < 514; c++) begin
            if (c < 512) begin
                r      = (c >> 5) & 15;
                c2     = c & 31;
                fl     = ((c >> 6) & 1) == 1;
                rd_en  = 1'b1;
                row    = 4'(r);
                col    = 5'(c2);
                flip_h = fl;
                exp_q.push_back(int'(gold(pix_addr(2, r, c2, fl))));
            end else begin
                rd_en = 1'b0;
            end
            step();
            if (color_valid) begin
                n_valid++;
                if (exp_q.size() == 0) begin
                    check("t6_extra_output", 32'd1, 32'd0);
                end else begin
                    e = 12'(exp_q.pop_front());
                    check($sformatf("t6_px%0d", n_valid - 1), 32'(color_data), 32'(e));
                end
            end
        end
        check("t6_count", 32'(n_valid), 32'd512);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
